wb_commit: RTL

- Sink end of the MEM/WB pipeline register. Consumes the registered wb_* bus and commits it to architectural state: the 32x32 general register file, HI, LO and LLbit.
- Serves ID-stage operand reads through two combinational read ports, with same-cycle WB-to-ID bypass.
- Exports HI/LO/LLbit to EX/MEM and a retired-instruction counter for debug.

---
 rtl/wb_commit_pkg.sv | 31 +++
 rtl/wb_commit_if.sv | 50 +++++
 rtl/wb_commit_regfile_2r1w.sv | 68 ++++++
 rtl/wb_commit.sv | 112 +++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// -----------------------------------------------------------------------------
// wb_commit_pkg
// Shared widths and constants for the write-back commit slice: bus widths,
// the hardwired-zero register address, enable encodings and the active-low
// reset level. Also holds the helper that decides whether a WB slot retires.
// -----------------------------------------------------------------------------
package wb_commit_pkg;

    localparam int REG_BUS      = 32;   // GPR / HI / LO data width
    localparam int REG_ADDR_BUS = 5;    // GPR address width
    localparam int INST_BUS     = 32;   // instruction word width

    localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = '0;
    localparam logic [REG_BUS-1:0]      ZERO_WORD    = '0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    // Reset is active-low in this pipeline.
    localparam logic RST_ENABLE = 1'b0;

    // A WB slot retires when it carries a real instruction and is not being
    // flushed. An all-zero instruction word marks a bubble.
    function automatic logic is_retire(input logic [INST_BUS-1:0] inst,
                                       input logic                flush);
        return (inst != '0) && !flush;
    endfunction

endpackage : wb_commit_pkg

// File: rtl/wb_commit_if.sv
// -----------------------------------------------------------------------------
// wb_commit_if
// Bundles the registered MEM/WB bus, the flush strobe and both ID-stage
// register read ports.
//   master : the pipeline side; drives wb_*, flush and read requests,
//            receives rdata1/rdata2.
//   slave  : wb_commit; consumes the bus and returns read data.
// -----------------------------------------------------------------------------
interface wb_commit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // MEM/WB register outputs
    logic [ADDR_W-1:0] wb_waddr;
    logic              wb_reg_we;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_hi_we;
    logic              wb_lo_we;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_llbit_we;
    logic              wb_llbit_value;
    logic [31:0]       wb_inst;
    logic              flush;

    // ID-stage read ports
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output wb_waddr, wb_reg_we, wb_wdata,
        output wb_hi_we, wb_lo_we, wb_hi, wb_lo,
        output wb_llbit_we, wb_llbit_value, wb_inst, flush,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  wb_waddr, wb_reg_we, wb_wdata,
        input  wb_hi_we, wb_lo_we, wb_hi, wb_lo,
        input  wb_llbit_we, wb_llbit_value, wb_inst, flush,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );

endinterface : wb_commit_if

// File: rtl/wb_commit_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// wb_commit_regfile_2r1w
// General register file: REG_NUM x DATA_W, one synchronous write port and
// two combinational read ports. Register 0 reads as zero and ignores writes.
// Each read port bypasses the write presented in the same cycle so ID sees
// the value WB is committing without a stall.
// Ports:
//   clk, rst       clock, synchronous active-low reset (clears every register)
//   we/waddr/wdata write port
//   re[i]/raddr[i] read request, port i (i = 0,1)
//   rdata[i]       read data, port i (combinational)
// -----------------------------------------------------------------------------
module wb_commit_regfile_2r1w
    import wb_commit_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [1:0]             re,
    input  logic [1:0][ADDR_W-1:0] raddr,
    output logic [1:0][DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs_reg [REG_NUM];

    // Reset clears the whole array, so this maps to registers rather than a
    // block RAM; the combinational read ports need that anyway.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we == WRITE_ENABLE && waddr != ADDR_W'(NOP_REG_ADDR)) begin
            regs_reg[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            logic [DATA_W-1:0] rdata_next;

            // Priority: reset, disabled port, r0, same-cycle bypass, array.
            always_comb begin
                rdata_next = DATA_W'(ZERO_WORD);
                if (rst == RST_ENABLE) begin
                    rdata_next = DATA_W'(ZERO_WORD);
                end else if (re[gi] == READ_DISABLE) begin
                    rdata_next = DATA_W'(ZERO_WORD);
                end else if (raddr[gi] == ADDR_W'(NOP_REG_ADDR)) begin
                    rdata_next = DATA_W'(ZERO_WORD);
                end else if (we == WRITE_ENABLE && raddr[gi] == waddr) begin
                    rdata_next = wdata;
                end else begin
                    rdata_next = regs_reg[raddr[gi]];
                end
            end

            assign rdata[gi] = rdata_next;
        end
    endgenerate

endmodule : wb_commit_regfile_2r1w

// File: rtl/wb_commit.sv
// -----------------------------------------------------------------------------
// wb_commit
// Sink of the MEM/WB pipeline register. Commits the WB bus into the GPR file,
// HI, LO and LLbit, serves the two ID read ports (with WB bypass) and counts
// retired instructions for debug.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   bus         wb_commit_if.slave: wb_* bus, flush, read ports 1/2
//   hi_o, lo_o  committed HI/LO (registered only, no bypass)
//   llbit_o     LLbit with same-cycle bypass of flush / LLbit write
//   retire_cnt  number of non-bubble, non-flushed instructions committed
// -----------------------------------------------------------------------------
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    wb_commit_if.slave        bus,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              llbit_o,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;
    logic              llbit_reg;
    logic [CNT_W-1:0]  retire_cnt_reg;

    logic [1:0]             rf_re;
    logic [1:0][ADDR_W-1:0] rf_raddr;
    logic [1:0][DATA_W-1:0] rf_rdata;

    assign rf_re    = {bus.re2, bus.re1};
    assign rf_raddr = {bus.raddr2, bus.raddr1};

    wb_commit_regfile_2r1w #(
        .REG_NUM (REG_NUM),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.wb_reg_we),
        .waddr (bus.wb_waddr),
        .wdata (bus.wb_wdata),
        .re    (rf_re),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    assign bus.rdata1 = rf_rdata[0];
    assign bus.rdata2 = rf_rdata[1];

    // HI and LO are independent; EX forwards from MEM/WB itself, so the
    // outputs carry the registered value only.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            if (bus.wb_hi_we == WRITE_ENABLE) hi_reg <= bus.wb_hi;
            if (bus.wb_lo_we == WRITE_ENABLE) lo_reg <= bus.wb_lo;
        end
    end

    // A flush (exception/eret) breaks any LL/SC pair, so it beats a
    // simultaneous LLbit write.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            llbit_reg <= 1'b0;
        end else if (bus.flush) begin
            llbit_reg <= 1'b0;
        end else if (bus.wb_llbit_we == WRITE_ENABLE) begin
            llbit_reg <= bus.wb_llbit_value;
        end
    end

    // Same-cycle view of LLbit so an SC in MEM sees the LL committing in WB.
    always_comb begin
        llbit_o = 1'b0;
        if (rst == RST_ENABLE) begin
            llbit_o = 1'b0;
        end else if (bus.flush) begin
            llbit_o = 1'b0;
        end else if (bus.wb_llbit_we == WRITE_ENABLE) begin
            llbit_o = bus.wb_llbit_value;
        end else begin
            llbit_o = llbit_reg;
        end
    end

    // Free-running modulo-2^CNT_W counter of retired instructions.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            retire_cnt_reg <= '0;
        end else if (is_retire(bus.wb_inst, bus.flush)) begin
            retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
        end
    end

    assign hi_o       = hi_reg;
    assign lo_o       = lo_reg;
    assign retire_cnt = retire_cnt_reg;

endmodule : wb_commit
